vga_frame_monitor: RTL and testbench

VGA_FRAME_MONITOR -- requirements
Module: vga_frame_monitor

---
 rtl/vga_frame_monitor.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_vga_frame_monitor.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_monitor.sv
// vga_frame_monitor: APB-programmable monitor for a VGA pixel stream.
// Measures active pixels per line (HACT), lines per frame (VACT) and
// counts frames. It flags a mismatch against an expected geometry,
// tracks a locked state and raises a level interrupt.
// Optional feature: define VGA_MON_CRC_EN to enable a per-frame CRC-32
// over the {r,g,b} pixel data. Without it, CRC reads as zero.
module vga_frame_monitor (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] in_paddr,
   input  logic        in_psel,
   input  logic        in_penable,
   input  logic [2:0]  in_pprot,
   input  logic        in_pwrite,
   input  logic [31:0] in_pwdata,
   input  logic [3:0]  in_pstrb,
   output logic        in_pready,
   output logic [31:0] in_prdata,
   output logic        in_pslverr,
   input  logic [7:0]  vga_r,
   input  logic [7:0]  vga_g,
   input  logic [7:0]  vga_b,
   input  logic        vga_hsync,
   input  logic        vga_vsync,
   input  logic        vga_valid,
   output logic        irq
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT_VS, S_MEASURE} state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic        r_enable;
   logic        r_irq_en;
   logic        r_locked;
   logic        r_pair_vld;
   logic        r_frame_done;
   logic        r_mismatch;
   logic [11:0] r_hact;
   logic [11:0] r_vact;
   logic [31:0] r_frames;
   logic [11:0] r_hexp;
   logic [11:0] r_vexp;
   logic [11:0] r_pix_cnt;
   logic [11:0] r_line_cnt;
   logic [11:0] r_line_len;
   logic        r_vs_prev;
   logic        r_vld_prev;

   logic        w_access;
   logic        w_bad;
   logic        w_wr;
   logic        w_wr_ctrl;
   logic        w_wr_stat;
   logic        w_wr_exp;
   logic        w_clear;
   logic        w_vs_fall;
   logic        w_line_end;
   logic        w_meas;
   logic        w_frame;
   logic        w_enter_meas;
   logic        w_leave_meas;
   logic [11:0] w_len_eff;
   logic [11:0] w_lines_eff;
   logic        w_mis_set;
   logic        w_pair_eq;
   logic [31:0] w_crc_rd;
   logic [31:0] w_rdata;

   function automatic logic [11:0] f_sat12(input logic [11:0] v);
      return (v == 12'hFFF) ? v : v + 12'd1;
   endfunction

   assign w_access   = in_psel & in_penable;
   assign w_bad      = (in_paddr[31:5] != 27'd0) | (in_paddr[4:2] == 3'd7);
   assign w_wr       = w_access & in_pwrite & ~w_bad;
   assign w_wr_ctrl  = w_wr & (in_paddr[4:2] == 3'd0);
   assign w_wr_stat  = w_wr & (in_paddr[4:2] == 3'd1);
   assign w_wr_exp   = w_wr & (in_paddr[4:2] == 3'd6);
   assign w_clear    = w_wr_ctrl & in_pwdata[2];

   // A frame boundary is the falling edge of vsync, a line end the falling edge of valid
   assign w_vs_fall  = r_vs_prev & ~vga_vsync;
   assign w_line_end = r_vld_prev & ~vga_valid;
   assign w_meas     = (r_state == S_MEASURE);
   assign w_frame    = w_meas & w_vs_fall;

   // A line ending on the boundary cycle is counted before the frame is latched
   assign w_len_eff   = w_line_end ? r_pix_cnt : r_line_len;
   assign w_lines_eff = w_line_end ? f_sat12(r_line_cnt) : r_line_cnt;
   assign w_mis_set   = w_frame & ({r_vexp, r_hexp} != 24'd0) &
                        ((w_len_eff != r_hexp) | (w_lines_eff != r_vexp));
   assign w_pair_eq   = (w_len_eff == r_hact) & (w_lines_eff == r_vact);

   assign w_enter_meas = (r_state == S_WAIT_VS) & (w_state_nxt == S_MEASURE);
   assign w_leave_meas = w_meas & (w_state_nxt != S_MEASURE);

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state: disable forces IDLE, clear restarts the search for a boundary
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:    if (r_enable) w_state_nxt = S_WAIT_VS;
         S_WAIT_VS: if (w_vs_fall) w_state_nxt = S_MEASURE;
         S_MEASURE: w_state_nxt = S_MEASURE;
         default:   w_state_nxt = S_IDLE;
      endcase
      if (!r_enable) w_state_nxt = S_IDLE;
      if (w_clear)   w_state_nxt = in_pwdata[0] ? S_WAIT_VS : S_IDLE;
   end

   // Previous vsync/valid samples for edge detection
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_vs_prev  <= 1'b1;
         r_vld_prev <= 1'b0;
      end else begin
         r_vs_prev  <= vga_vsync;
         r_vld_prev <= vga_valid;
      end
   end

   // Software-controlled CTRL and EXPECT fields
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_enable <= 1'b0;
         r_irq_en <= 1'b0;
         r_hexp   <= 12'd0;
         r_vexp   <= 12'd0;
      end else begin
         if (w_wr_ctrl) begin
            r_enable <= in_pwdata[0];
            r_irq_en <= in_pwdata[1];
         end
         if (w_wr_exp) begin
            r_hexp <= in_pwdata[11:0];
            r_vexp <= in_pwdata[27:16];
         end
      end
   end

   // Pixel and line counters, active only while measuring
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_pix_cnt  <= 12'd0;
         r_line_cnt <= 12'd0;
         r_line_len <= 12'd0;
      end else if (w_clear) begin
         r_pix_cnt  <= 12'd0;
         r_line_cnt <= 12'd0;
         r_line_len <= 12'd0;
      end else if (w_enter_meas) begin
         r_pix_cnt  <= 12'd0;
         r_line_cnt <= 12'd0;
      end else if (w_meas) begin
         if (w_line_end) r_line_len <= r_pix_cnt;
         if (w_frame) begin
            r_pix_cnt  <= 12'd0;
            r_line_cnt <= 12'd0;
         end else if (w_line_end) begin
            r_pix_cnt  <= 12'd0;
            r_line_cnt <= f_sat12(r_line_cnt);
         end else if (vga_valid) begin
            r_pix_cnt  <= f_sat12(r_pix_cnt);
         end
      end
   end

   // Per-frame latches and lock tracking
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_hact     <= 12'd0;
         r_vact     <= 12'd0;
         r_frames   <= 32'd0;
         r_pair_vld <= 1'b0;
         r_locked   <= 1'b0;
      end else if (w_clear) begin
         r_hact     <= 12'd0;
         r_vact     <= 12'd0;
         r_frames   <= 32'd0;
         r_pair_vld <= 1'b0;
         r_locked   <= 1'b0;
      end else begin
         if (w_frame) begin
            r_hact     <= w_len_eff;
            r_vact     <= w_lines_eff;
            r_frames   <= r_frames + 32'd1;
            r_pair_vld <= 1'b1;
            r_locked   <= r_pair_vld & w_pair_eq;
         end
         if (w_leave_meas) begin
            r_pair_vld <= 1'b0;
            r_locked   <= 1'b0;
         end
      end
   end

   // Sticky status bits: clear beats everything, hardware set beats W1C
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_frame_done <= 1'b0;
         r_mismatch   <= 1'b0;
      end else if (w_clear) begin
         r_frame_done <= 1'b0;
         r_mismatch   <= 1'b0;
      end else begin
         if (w_frame)                       r_frame_done <= 1'b1;
         else if (w_wr_stat & in_pwdata[1]) r_frame_done <= 1'b0;
         if (w_mis_set)                     r_mismatch   <= 1'b1;
         else if (w_wr_stat & in_pwdata[2]) r_mismatch   <= 1'b0;
      end
   end

`ifdef VGA_MON_CRC_EN
   localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;
   localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

   logic [31:0] r_crc_run;
   logic [31:0] r_crc;

   function automatic logic [31:0] f_crc24(input logic [31:0] c, input logic [23:0] d);
      logic [31:0] v;
      logic        fb;
      v = c;
      for (int i = 23; i >= 0; i--) begin
         fb = v[31] ^ d[i];
         v  = {v[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0);
      end
      return v;
   endfunction

   // Running CRC over valid pixels, latched and restarted at each frame boundary
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_crc_run <= CRC_INIT;
         r_crc     <= 32'd0;
      end else if (w_clear) begin
         r_crc_run <= CRC_INIT;
         r_crc     <= 32'd0;
      end else if (w_enter_meas) begin
         r_crc_run <= CRC_INIT;
      end else if (w_frame) begin
         r_crc     <= r_crc_run;
         r_crc_run <= CRC_INIT;
      end else if (w_meas & vga_valid) begin
         r_crc_run <= f_crc24(r_crc_run, {vga_r, vga_g, vga_b});
      end
   end

   assign w_crc_rd = r_crc;

   logic w_unused_ok;
   assign w_unused_ok = ^{in_pprot, in_pstrb, vga_hsync, in_paddr[1:0],
                          in_pwdata[31:28], in_pwdata[15:12]};
`else
   assign w_crc_rd = 32'd0;

   logic w_unused_ok;
   assign w_unused_ok = ^{in_pprot, in_pstrb, vga_hsync, in_paddr[1:0],
                          in_pwdata[31:28], in_pwdata[15:12], vga_r, vga_g, vga_b};
`endif

   // Register read mux; zero when not selected or on a bad offset
   always_comb begin
      w_rdata = 32'd0;
      if (in_psel && !w_bad) begin
         case (in_paddr[4:2])
            3'd0:    w_rdata = {30'd0, r_irq_en, r_enable};
            3'd1:    w_rdata = {29'd0, r_mismatch, r_frame_done, r_locked};
            3'd2:    w_rdata = {20'd0, r_hact};
            3'd3:    w_rdata = {20'd0, r_vact};
            3'd4:    w_rdata = r_frames;
            3'd5:    w_rdata = w_crc_rd;
            3'd6:    w_rdata = {4'd0, r_vexp, 4'd0, r_hexp};
            default: w_rdata = 32'd0;
         endcase
      end
   end

   assign in_prdata  = w_rdata;
   assign in_pready  = w_access;
   assign in_pslverr = w_access & w_bad;
   assign irq        = r_irq_en & (r_frame_done | r_mismatch);

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Directed testbench for vga_frame_monitor. Honours VGA_MON_CRC_EN when defined.
module tb_vga_frame_monitor;

   logic        clock;
   logic        reset;
   logic [31:0] in_paddr;
   logic        in_psel;
   logic        in_penable;
   logic [2:0]  in_pprot;
   logic        in_pwrite;
   logic [31:0] in_pwdata;
   logic [3:0]  in_pstrb;
   logic        in_pready;
   logic [31:0] in_prdata;
   logic        in_pslverr;
   logic [7:0]  vga_r;
   logic [7:0]  vga_g;
   logic [7:0]  vga_b;
   logic        vga_hsync;
   logic        vga_vsync;
   logic        vga_valid;
   logic        irq;

   int          n_checks;
   int          n_errors;
   logic [31:0] rd;
   logic        er;
   logic        rdy;

   vga_frame_monitor dut (
      .clock(clock), .reset(reset),
      .in_paddr(in_paddr), .in_psel(in_psel), .in_penable(in_penable),
      .in_pprot(in_pprot), .in_pwrite(in_pwrite), .in_pwdata(in_pwdata),
      .in_pstrb(in_pstrb), .in_pready(in_pready), .in_prdata(in_prdata),
      .in_pslverr(in_pslverr), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
      .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_valid(vga_valid),
      .irq(irq)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [31:0] crc_model(input logic [31:0] c, input logic [23:0] px);
      logic [31:0] r;
      r = c;
      for (int b = 0; b < 3; b++) begin
         r = r ^ {px[23 - 8*b -: 8], 24'd0};
         for (int k = 0; k < 8; k++)
            r = r[31] ? ((r << 1) ^ 32'h04C1_1DB7) : (r << 1);
      end
      return r;
   endfunction

   task automatic drive(input logic v, input logic vs);
      vga_valid = v;
      vga_vsync = vs;
      @(posedge clock); #1;
   endtask

   task automatic send_line(input int n);
      repeat (n) drive(1'b1, 1'b1);
      drive(1'b0, 1'b1);
      drive(1'b0, 1'b1);
   endtask

   task automatic send_frame(input int lines, input int n);
      for (int l = 0; l < lines; l++) send_line(n);
      drive(1'b0, 1'b0);
      drive(1'b0, 1'b0);
      drive(1'b0, 1'b1);
      drive(1'b0, 1'b1);
   endtask

   task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
      in_paddr = a; in_pwdata = d; in_pwrite = 1'b1; in_psel = 1'b1; in_penable = 1'b0;
      @(posedge clock); #1;
      in_penable = 1'b1;
      @(posedge clock); #1;
      in_psel = 1'b0; in_penable = 1'b0; in_pwrite = 1'b0;
   endtask

   task automatic apb_read(input logic [31:0] a, output logic [31:0] d, output logic e);
      in_paddr = a; in_pwrite = 1'b0; in_psel = 1'b1; in_penable = 1'b0;
      @(posedge clock); #1;
      in_penable = 1'b1;
      #1;
      d   = in_prdata;
      e   = in_pslverr;
      rdy = in_pready;
      @(posedge clock); #1;
      in_psel = 1'b0; in_penable = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      n_checks++; if ({in_pready, in_pslverr, irq} !== 3'b000) begin n_errors++; $display("FAIL reset_outputs got %b exp 000", {in_pready, in_pslverr, irq}); end
      n_checks++; if (in_prdata !== 32'd0) begin n_errors++; $display("FAIL reset_prdata got %h exp 0", in_prdata); end
      reset = 1'b0;
      @(posedge clock); #1;
      for (int a = 0; a < 7; a++) begin
         apb_read(32'(a * 4), rd, er);
         n_checks++; if (rd !== 32'd0) begin n_errors++; $display("FAIL reset_reg%0d got %h exp 0", a, rd); end
      end
   endtask

   task automatic test_basic;
      apb_write(32'h0, 32'h1);
      repeat (2) drive(1'b0, 1'b1);
      repeat (3) send_frame(4, 8);
      apb_read(32'h08, rd, er);
      n_checks++; if (rd !== 32'd8) begin n_errors++; $display("FAIL basic_hact got %0d exp 8", rd); end
      apb_read(32'h0C, rd, er);
      n_checks++; if (rd !== 32'd4) begin n_errors++; $display("FAIL basic_vact got %0d exp 4", rd); end
      apb_read(32'h10, rd, er);
      n_checks++; if (rd !== 32'd2) begin n_errors++; $display("FAIL basic_frames got %0d exp 2", rd); end
      apb_read(32'h04, rd, er);
      n_checks++; if (rd !== 32'h3) begin n_errors++; $display("FAIL basic_status got %h exp 3", rd); end
      n_checks++; if (irq !== 1'b0) begin n_errors++; $display("FAIL basic_irq got %b exp 0", irq); end
   endtask

   task automatic test_mismatch;
      apb_write(32'h18, 32'h0004_0008);
      apb_write(32'h00, 32'h3);
      send_frame(4, 7);
      apb_read(32'h04, rd, er);
      n_checks++; if (rd !== 32'h6) begin n_errors++; $display("FAIL mis_status got %h exp 6", rd); end
      n_checks++; if (irq !== 1'b1) begin n_errors++; $display("FAIL mis_irq_on got %b exp 1", irq); end
      apb_write(32'h00, 32'h1);
      n_checks++; if (irq !== 1'b0) begin n_errors++; $display("FAIL mis_irq_off got %b exp 0", irq); end
      apb_write(32'h04, 32'h6);
      apb_read(32'h04, rd, er);
      n_checks++; if (rd !== 32'h0) begin n_errors++; $display("FAIL mis_w1c got %h exp 0", rd); end
   endtask

   task automatic test_coincide_w1c;
      for (int l = 0; l < 4; l++) send_line(8);
      in_paddr = 32'h04; in_pwdata = 32'h6; in_pwrite = 1'b1; in_psel = 1'b1; in_penable = 1'b0;
      drive(1'b0, 1'b1);
      in_penable = 1'b1;
      drive(1'b0, 1'b0);
      in_psel = 1'b0; in_penable = 1'b0; in_pwrite = 1'b0;
      drive(1'b0, 1'b0); drive(1'b0, 1'b1); drive(1'b0, 1'b1);
      apb_read(32'h04, rd, er);
      n_checks++; if (rd !== 32'h2) begin n_errors++; $display("FAIL w1c_vs_set got %h exp 2", rd); end
      apb_read(32'h10, rd, er);
      n_checks++; if (rd !== 32'd4) begin n_errors++; $display("FAIL w1c_frames got %0d exp 4", rd); end
   endtask

   task automatic test_coincide_clear;
      for (int l = 0; l < 4; l++) send_line(8);
      in_paddr = 32'h00; in_pwdata = 32'h5; in_pwrite = 1'b1; in_psel = 1'b1; in_penable = 1'b0;
      drive(1'b0, 1'b1);
      in_penable = 1'b1;
      drive(1'b0, 1'b0);
      in_psel = 1'b0; in_penable = 1'b0; in_pwrite = 1'b0;
      drive(1'b0, 1'b0); drive(1'b0, 1'b1); drive(1'b0, 1'b1);
      apb_read(32'h08, rd, er);
      n_checks++; if (rd !== 32'd0) begin n_errors++; $display("FAIL clr_hact got %0d exp 0", rd); end
      apb_read(32'h0C, rd, er);
      n_checks++; if (rd !== 32'd0) begin n_errors++; $display("FAIL clr_vact got %0d exp 0", rd); end
      apb_read(32'h10, rd, er);
      n_checks++; if (rd !== 32'd0) begin n_errors++; $display("FAIL clr_frames got %0d exp 0", rd); end
      apb_read(32'h04, rd, er);
      n_checks++; if (rd !== 32'd0) begin n_errors++; $display("FAIL clr_status got %h exp 0", rd); end
      apb_read(32'h00, rd, er);
      n_checks++; if (rd !== 32'h1) begin n_errors++; $display("FAIL clr_ctrl got %h exp 1", rd); end
      send_frame(4, 8);
      apb_read(32'h10, rd, er);
      n_checks++; if (rd !== 32'd0) begin n_errors++; $display("FAIL clr_first_frame got %0d exp 0", rd); end
      send_frame(4, 8);
      apb_read(32'h10, rd, er);
      n_checks++; if (rd !== 32'd1) begin n_errors++; $display("FAIL clr_second_frame got %0d exp 1", rd); end
   endtask

   task automatic test_line_at_vsync;
      for (int l = 0; l < 3; l++) send_line(8);
      repeat (8) drive(1'b1, 1'b1);
      drive(1'b0, 1'b0);
      drive(1'b0, 1'b0); drive(1'b0, 1'b1); drive(1'b0, 1'b1);
      apb_read(32'h0C, rd, er);
      n_checks++; if (rd !== 32'd4) begin n_errors++; $display("FAIL coin_vact got %0d exp 4", rd); end
      apb_read(32'h08, rd, er);
      n_checks++; if (rd !== 32'd8) begin n_errors++; $display("FAIL coin_hact got %0d exp 8", rd); end
      apb_read(32'h04, rd, er);
      n_checks++; if (rd !== 32'h3) begin n_errors++; $display("FAIL coin_status got %h exp 3", rd); end
   endtask

   task automatic test_slverr;
      apb_read(32'h1C, rd, er);
      n_checks++; if ({rdy, er, rd} !== {1'b1, 1'b1, 32'd0}) begin n_errors++; $display("FAIL err_1c got rdy=%b err=%b data=%h exp 1 1 0", rdy, er, rd); end
      apb_read(32'h20, rd, er);
      n_checks++; if ({rdy, er, rd} !== {1'b1, 1'b1, 32'd0}) begin n_errors++; $display("FAIL err_20 got rdy=%b err=%b data=%h exp 1 1 0", rdy, er, rd); end
      apb_read(32'h04, rd, er);
      n_checks++; if (er !== 1'b0) begin n_errors++; $display("FAIL err_good got %b exp 0", er); end
      apb_write(32'h1C, 32'hFFFF_FFFF);
      apb_write(32'h20, 32'h2);
      apb_write(32'h38, 32'h0000_0FFF);
      apb_read(32'h00, rd, er);
      n_checks++; if (rd !== 32'h1) begin n_errors++; $display("FAIL err_ctrl_kept got %h exp 1", rd); end
      apb_read(32'h18, rd, er);
      n_checks++; if (rd !== 32'h0004_0008) begin n_errors++; $display("FAIL err_exp_kept got %h exp 00040008", rd); end
   endtask

   task automatic test_crc;
      logic [31:0] exp_crc;
      vga_r = 8'h00; vga_g = 8'h00; vga_b = 8'h00;
      apb_write(32'h00, 32'h5);
      repeat (3) send_frame(1, 1);
`ifdef VGA_MON_CRC_EN
      exp_crc = crc_model(32'hFFFF_FFFF, 24'h000000);
`else
      exp_crc = 32'd0;
`endif
      apb_read(32'h14, rd, er);
      n_checks++; if (rd !== exp_crc) begin n_errors++; $display("FAIL crc got %h exp %h", rd, exp_crc); end
      apb_read(32'h08, rd, er);
      n_checks++; if (rd !== 32'd1) begin n_errors++; $display("FAIL crc_hact got %0d exp 1", rd); end
      apb_read(32'h04, rd, er);
      n_checks++; if (rd !== 32'h7) begin n_errors++; $display("FAIL crc_status got %h exp 7", rd); end
   endtask

   task automatic test_reset_midframe;
      apb_write(32'h18, 32'h0);
      send_line(8); send_line(8);
      drive(1'b1, 1'b1); drive(1'b1, 1'b1);
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      vga_valid = 1'b0;
      drive(1'b0, 1'b1);
      apb_read(32'h10, rd, er);
      n_checks++; if (rd !== 32'd0) begin n_errors++; $display("FAIL rst_frames got %0d exp 0", rd); end
      apb_read(32'h00, rd, er);
      n_checks++; if (rd !== 32'd0) begin n_errors++; $display("FAIL rst_ctrl got %h exp 0", rd); end
      apb_write(32'h00, 32'h1);
      send_frame(4, 8);
      send_frame(4, 8);
      apb_read(32'h10, rd, er);
      n_checks++; if (rd !== 32'd1) begin n_errors++; $display("FAIL rst_relatch got %0d exp 1", rd); end
      send_frame(4, 8);
      apb_read(32'h04, rd, er);
      n_checks++; if (rd !== 32'h3) begin n_errors++; $display("FAIL rst_locked got %h exp 3", rd); end
      apb_write(32'h00, 32'h0);
      drive(1'b0, 1'b1); drive(1'b0, 1'b1);
      apb_read(32'h04, rd, er);
      n_checks++; if (rd !== 32'h2) begin n_errors++; $display("FAIL dis_unlock got %h exp 2", rd); end
      send_frame(4, 8);
      apb_read(32'h10, rd, er);
      n_checks++; if (rd !== 32'd2) begin n_errors++; $display("FAIL dis_frames got %0d exp 2", rd); end
   endtask

   initial begin
      n_checks = 0; n_errors = 0;
      reset = 1'b1;
      in_paddr = 32'd0; in_psel = 1'b0; in_penable = 1'b0; in_pprot = 3'd0;
      in_pwrite = 1'b0; in_pwdata = 32'd0; in_pstrb = 4'hF;
      vga_r = 8'h00; vga_g = 8'h00; vga_b = 8'h00;
      vga_hsync = 1'b1; vga_vsync = 1'b1; vga_valid = 1'b0;
      rd = 32'd0; er = 1'b0; rdy = 1'b0;
      test_reset;
      test_basic;
      test_mismatch;
      test_coincide_w1c;
      test_coincide_clear;
      test_line_at_vsync;
      test_slverr;
      test_crc;
      test_reset_midframe;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
